// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - shared GF(2^8) constants, arithmetic helpers and stage state encodings
package rs_pkg;

   // Primitive polynomial x^8+x^4+x^3+x^2+1 and the alpha powers the Chien/Forney steps use
   localparam logic [8:0] GF_PRIM_POLY = 9'h11D;
   localparam logic [7:0] GF_ALPHA     = 8'h02;
   localparam logic [7:0] GF_ALPHA2    = 8'h04;
   localparam logic [7:0] GF_ALPHA_INV = 8'h8E;

   // One-hot Chien/Forney stage states
   typedef enum logic [2:0] {
      ST_IDLE = 3'b001,
      ST_SCAN = 3'b010,
      ST_DONE = 3'b100
   } chs_state_t;

   // Shift-and-add GF(2^8) multiply
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = sh[7] ? ({sh[6:0], 1'b0} ^ GF_PRIM_POLY[7:0]) : {sh[6:0], 1'b0};
      end
      return acc;
   endfunction

   // Square-and-multiply power a^e for 0 <= e < 256
   function automatic logic [7:0] gf_pow(input logic [7:0] a, input int e);
      logic [7:0] acc;
      logic [7:0] base;
      int         k;
      acc  = 8'h01;
      base = a;
      k    = e;
      for (int i = 0; i < 8; i++) begin
         if (k[i]) acc = gf_mul(acc, base);
         base = gf_mul(base, base);
      end
      return acc;
   endfunction

   // alpha^e with the exponent reduced modulo the field order
   function automatic logic [7:0] alpha_pow(input int e);
      return gf_pow(GF_ALPHA, e % 255);
   endfunction

endpackage

// File: rtl/gf2m8_inverse.sv
// rtl/gf2m8_inverse.sv - combinational GF(2^8) inverse (a^254, zero maps to zero)
module gf2m8_inverse
   import rs_pkg::*;
(
   input  logic [7:0] a,
   output logic [7:0] y
);

   assign y = gf_pow(a, 254);

endmodule

// File: rtl/gf2m8_multi.sv
// rtl/gf2m8_multi.sv - combinational GF(2^8) multiplier
module gf2m8_multi
   import rs_pkg::*;
(
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] p
);

   assign p = gf_mul(a, b);

endmodule

// File: rtl/s3_chs_forney.sv
// rtl/s3_chs_forney.sv - t=2 Chien search and Forney magnitudes; S3_CHS_FAIL_CHK_EN enables root counting and chs_fail
module s3_chs_forney
   import rs_pkg::*;
#(
   parameter int RS_N = 255
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       kes_done,
   input  logic [7:0] rs_lambda0,
   input  logic [7:0] rs_lambda1,
   input  logic [7:0] rs_lambda2,
   input  logic [7:0] rs_omega0,
   input  logic [7:0] rs_omega1,
   output logic       chs_err_vld,
   output logic [7:0] chs_err_val,
   output logic       chs_err_loc,
   output logic       chs_sof,
   output logic       chs_eof,
   output logic       chs_done,
   output logic       chs_fail,
   output logic       chs_overrun
);

   // Seeds place the terms at position RS_N-1; each scan cycle steps one position down
   localparam logic [7:0] POS_TOP = 8'(RS_N - 1);
   localparam logic [7:0] SEED_T1 = alpha_pow(255 - (RS_N - 1));
   localparam logic [7:0] SEED_T2 = alpha_pow(510 - 2 * (RS_N - 1));
   localparam logic [7:0] SEED_FN = alpha_pow(RS_N - 1);

   chs_state_t state, state_nxt;
   logic       is_idle, is_scan, is_done, start;
   logic [7:0] lam0, lam1, om1, l1_inv;
   logic [7:0] term1, term2, fterm, pos;
   logic [7:0] m1_a, m1_b, m2_a, m2_b, m3_a, m3_b;
   logic [7:0] t1_nxt, t2_nxt, fn_nxt, l1_inv_in;
   logic [7:0] chien_sum, fn_num, err_mag;
   logic       is_root;
   logic       fail_cond;

   assign is_idle = (state == ST_IDLE);
   assign is_scan = (state == ST_SCAN);
   assign is_done = (state == ST_DONE);
   assign start   = is_idle & kes_done;

   // In IDLE the multipliers form the seeds from the inputs; in SCAN they step the terms
   assign m1_a = is_idle ? rs_lambda1 : term1;
   assign m1_b = is_idle ? SEED_T1    : GF_ALPHA;
   assign m2_a = is_idle ? rs_lambda2 : term2;
   assign m2_b = is_idle ? SEED_T2    : GF_ALPHA2;
   assign m3_a = is_idle ? rs_omega0  : fterm;
   assign m3_b = is_idle ? SEED_FN    : GF_ALPHA_INV;

   gf2m8_multi   u_mul_t1  (.a(m1_a),   .b(m1_b),   .p(t1_nxt));
   gf2m8_multi   u_mul_t2  (.a(m2_a),   .b(m2_b),   .p(t2_nxt));
   gf2m8_multi   u_mul_fn  (.a(m3_a),   .b(m3_b),   .p(fn_nxt));
   gf2m8_multi   u_mul_val (.a(fn_num), .b(l1_inv), .p(err_mag));
   gf2m8_inverse u_inv     (.a(rs_lambda1), .y(l1_inv_in));

   assign chien_sum = lam0 ^ term1 ^ term2;
   assign is_root   = (chien_sum == 8'h00);
   assign fn_num    = fterm ^ om1;

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next state: start from IDLE, leave SCAN after position 0, DONE lasts one cycle
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (kes_done) state_nxt = ST_SCAN;
         ST_SCAN: if (pos == 8'h00) state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Coefficient capture on start, term stepping and position count-down during SCAN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         lam0   <= 8'h00;
         lam1   <= 8'h00;
         om1    <= 8'h00;
         l1_inv <= 8'h00;
         term1  <= 8'h00;
         term2  <= 8'h00;
         fterm  <= 8'h00;
         pos    <= 8'h00;
      end else if (start) begin
         lam0   <= rs_lambda0;
         lam1   <= rs_lambda1;
         om1    <= rs_omega1;
         l1_inv <= l1_inv_in;
         term1  <= t1_nxt;
         term2  <= t2_nxt;
         fterm  <= fn_nxt;
         pos    <= POS_TOP;
      end else if (is_scan) begin
         term1  <= t1_nxt;
         term2  <= t2_nxt;
         fterm  <= fn_nxt;
         pos    <= pos - 8'd1;
      end
   end

`ifdef S3_CHS_FAIL_CHK_EN
   logic [7:0] lam2;
   logic [1:0] root_cnt;
   logic [1:0] lam_deg;

   // Saturating root count per codeword, plus lambda2 kept for the degree check
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         lam2     <= 8'h00;
         root_cnt <= 2'd0;
      end else if (start) begin
         lam2     <= rs_lambda2;
         root_cnt <= 2'd0;
      end else if (is_scan && is_root && root_cnt != 2'd3) begin
         root_cnt <= root_cnt + 2'd1;
      end
   end

   assign lam_deg   = (lam2 != 8'h00) ? 2'd2 : ((lam1 != 8'h00) ? 2'd1 : 2'd0);
   assign fail_cond = (root_cnt != lam_deg) | ((lam2 != 8'h00) & (lam1 == 8'h00));
`else
   assign fail_cond = 1'b0;
`endif

   // Registered slot outputs; a zero lambda1 never produces a magnitude
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         chs_err_vld <= 1'b0;
         chs_err_val <= 8'h00;
         chs_err_loc <= 1'b0;
         chs_sof     <= 1'b0;
         chs_eof     <= 1'b0;
         chs_done    <= 1'b0;
         chs_fail    <= 1'b0;
         chs_overrun <= 1'b0;
      end else begin
         chs_err_vld <= is_scan;
         chs_err_val <= (is_scan && is_root && lam1 != 8'h00) ? err_mag : 8'h00;
         chs_err_loc <= is_scan & is_root;
         chs_sof     <= is_scan & (pos == POS_TOP);
         chs_eof     <= is_scan & (pos == 8'h00);
         chs_done    <= is_done;
         chs_fail    <= is_done & fail_cond;
         chs_overrun <= kes_done & ~is_idle;
      end
   end

endmodule

// File: tb/tb_s3_chs_forney.sv
// tb/tb_s3_chs_forney.sv - self-checking bench for s3_chs_forney against a polynomial-evaluation model
`timescale 1ns/1ps
module tb_s3_chs_forney;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       kes_done = 1'b0;
   logic [7:0] l0 = 8'h00, l1 = 8'h00, l2 = 8'h00, o0 = 8'h00, o1 = 8'h00;

   logic       a_vld, a_loc, a_sof, a_eof, a_done, a_fail, a_ovr;
   logic [7:0] a_val;
   logic       b_vld, b_loc, b_sof, b_eof, b_done, b_fail, b_ovr;
   logic [7:0] b_val;

   always #5 clk = ~clk;

   s3_chs_forney #(.RS_N(255)) u_dut255 (
      .clk(clk), .rstn(rstn), .kes_done(kes_done),
      .rs_lambda0(l0), .rs_lambda1(l1), .rs_lambda2(l2),
      .rs_omega0(o0), .rs_omega1(o1),
      .chs_err_vld(a_vld), .chs_err_val(a_val), .chs_err_loc(a_loc),
      .chs_sof(a_sof), .chs_eof(a_eof), .chs_done(a_done),
      .chs_fail(a_fail), .chs_overrun(a_ovr)
   );

   s3_chs_forney #(.RS_N(5)) u_dut5 (
      .clk(clk), .rstn(rstn), .kes_done(kes_done),
      .rs_lambda0(l0), .rs_lambda1(l1), .rs_lambda2(l2),
      .rs_omega0(o0), .rs_omega1(o1),
      .chs_err_vld(b_vld), .chs_err_val(b_val), .chs_err_loc(b_loc),
      .chs_sof(b_sof), .chs_eof(b_eof), .chs_done(b_done),
      .chs_fail(b_fail), .chs_overrun(b_ovr)
   );

   // Packed view: {vld, val[7:0], loc, sof, eof, done, fail, overrun}
   logic [14:0] act_vec [2];
   logic [14:0] exp_vec [2];
   assign act_vec[0] = {a_vld, a_val, a_loc, a_sof, a_eof, a_done, a_fail, a_ovr};
   assign act_vec[1] = {b_vld, b_val, b_loc, b_sof, b_eof, b_done, b_fail, b_ovr};

   int n_chk = 0;
   int n_fail = 0;

   // Log/antilog tables of GF(2^8) over 0x11D
   int alog [0:255];
   int lg   [0:255];

   function automatic int gmul(int a, int b);
      if (a == 0 || b == 0) return 0;
      return alog[(lg[a] + lg[b]) % 255];
   endfunction

   function automatic int ginv(int a);
      if (a == 0) return 0;
      return alog[(255 - lg[a]) % 255];
   endfunction

   // Root test: evaluate Lambda at alpha^-j
   function automatic int m_loc(int j, int a0, int a1, int a2);
      int x;
      x = alog[(255 - j) % 255];
      return ((a0 ^ gmul(a1, x) ^ gmul(a2, gmul(x, x))) == 0) ? 1 : 0;
   endfunction

   function automatic int m_val(int j, int a0, int a1, int a2, int w0, int w1);
      if (m_loc(j, a0, a1, a2) == 0 || a1 == 0) return 0;
      return gmul(gmul(w0, alog[j]) ^ w1, ginv(a1));
   endfunction

   // Model state per instance: phase 0 idle, 1 scanning, 2 done
   int ph [2], pj [2], nroot [2];
   int ml0 [2], ml1 [2], ml2 [2], mo0 [2], mo1 [2];

   // Observed statistics of the current scenario
   int st_slots, st_loc, st_nz, st_done, st_fail, st_ovr, st_eof, st_eof_val, st_sof_val;
   int st5_sof, st5_eof, st5_slots;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic clr_stats();
      st_slots = 0; st_loc = 0; st_nz = 0; st_done = 0; st_fail = 0; st_ovr = 0;
      st_eof = 0; st_eof_val = -1; st_sof_val = -1;
      st5_sof = 0; st5_eof = 0; st5_slots = 0;
   endtask

   task automatic pulse(input int a0, input int a1, input int a2, input int w0, input int w1);
      @(posedge clk); #1;
      l0 = a0[7:0]; l1 = a1[7:0]; l2 = a2[7:0]; o0 = w0[7:0]; o1 = w1[7:0];
      kes_done = 1'b1;
      @(posedge clk); #1;
      kes_done = 1'b0;
   endtask

   task automatic run_cw(input int a0, input int a1, input int a2, input int w0, input int w1);
      clr_stats();
      pulse(a0, a1, a2, w0, w1);
      repeat (260) @(posedge clk);
   endtask

   int exp_fail_035;
   int p1, p2, xa, xb, mode, late;

   initial begin
      alog[0] = 1;
      lg[0]   = 0;
      lg[1]   = 0;
      for (int i = 1; i < 256; i++) begin
         alog[i] = alog[i-1] * 2;
         if (alog[i] >= 256) alog[i] = alog[i] ^ 'h11D;
         if (i < 255) lg[alog[i]] = i;
      end
      clr_stats();

      fork
         // Reference model: what each edge must register, from the polynomial definitions
         forever begin
            int old, nn, lc, vv, dg;
            logic ef;
            @(posedge clk or negedge rstn);
            for (int i = 0; i < 2; i++) begin
               if (!rstn) begin
                  ph[i] = 0; pj[i] = 0; nroot[i] = 0; exp_vec[i] = '0;
               end else begin
                  nn  = (i == 0) ? 255 : 5;
                  old = ph[i];
                  exp_vec[i] = '0;
                  if (old == 1) begin
                     lc = m_loc(pj[i], ml0[i], ml1[i], ml2[i]);
                     vv = m_val(pj[i], ml0[i], ml1[i], ml2[i], mo0[i], mo1[i]);
                     nroot[i] += lc;
                     exp_vec[i][14]   = 1'b1;
                     exp_vec[i][13:6] = vv[7:0];
                     exp_vec[i][5]    = lc[0];
                     exp_vec[i][4]    = (pj[i] == nn - 1);
                     exp_vec[i][3]    = (pj[i] == 0);
                     if (pj[i] == 0) ph[i] = 2;
                     else pj[i] = pj[i] - 1;
                  end else if (old == 2) begin
`ifdef S3_CHS_FAIL_CHK_EN
                     dg = (ml2[i] != 0) ? 2 : ((ml1[i] != 0) ? 1 : 0);
                     ef = (nroot[i] != dg) || (ml2[i] != 0 && ml1[i] == 0);
`else
                     dg = 0;
                     ef = 1'b0;
`endif
                     exp_vec[i][2] = 1'b1;
                     exp_vec[i][1] = ef;
                     ph[i] = 0;
                  end
                  exp_vec[i][0] = kes_done && (old != 0);
                  if (old == 0 && kes_done) begin
                     ml0[i] = l0; ml1[i] = l1; ml2[i] = l2; mo0[i] = o0; mo1[i] = o1;
                     ph[i] = 1; pj[i] = nn - 1; nroot[i] = 0;
                  end
               end
            end
         end
         // Per-cycle compare of both instances, plus scenario statistics
         forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
               n_chk++;
               if (act_vec[i] !== exp_vec[i]) begin
                  n_fail++;
                  $display("FAIL outputs_dut%0d t=%0t got %h expected %h (vld,val,loc,sof,eof,done,fail,ovr)",
                           i, $time, act_vec[i], exp_vec[i]);
               end
            end
            if (a_vld) st_slots++;
            if (a_loc) st_loc++;
            if (a_val != 8'h00) st_nz++;
            if (a_done) st_done++;
            if (a_fail) st_fail++;
            if (a_ovr) st_ovr++;
            if (a_eof) begin st_eof++; st_eof_val = a_val; end
            if (a_sof) st_sof_val = a_val;
            if (b_sof) st5_sof++;
            if (b_eof) st5_eof++;
            if (b_vld) st5_slots++;
         end
      join_none

      // Hand-computed pins of the model itself
      chk("pin_gmul_8e_02", gmul('h8E, 2), 1);
      chk("pin_val_j0", m_val(0, 1, 1, 0, 'h5A, 0), 'h5A);
      chk("pin_loc_j1", m_loc(1, 1, 1, 0), 0);
      chk("pin_val_j254", m_val(254, 1, 'h8E, 0, 1, 0), 1);

      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs_255", int'(act_vec[0]), 0);
      chk("reset_outputs_5", int'(act_vec[1]), 0);
      rstn = 1'b1;
      repeat (2) @(posedge clk);

      // No errors
      run_cw(1, 0, 0, 0, 0);
      chk("clean_slots", st_slots, 255);
      chk("clean_locs", st_loc, 0);
      chk("clean_nonzero_vals", st_nz, 0);
      chk("clean_done", st_done, 1);
      chk("clean_fail", st_fail, 0);
      chk("n5_sof_count", st5_sof, 1);
      chk("n5_eof_count", st5_eof, 1);
      chk("n5_slots", st5_slots, 5);

      // Single error at position 0
      run_cw(1, 1, 0, 'h5A, 0);
      chk("pos0_locs", st_loc, 1);
      chk("pos0_eof_val", st_eof_val, 'h5A);
      chk("pos0_nonzero_vals", st_nz, 1);
      chk("pos0_fail", st_fail, 0);

      // Single error at position 254
      run_cw(1, 'h8E, 0, 1, 0);
      chk("pos254_sof_val", st_sof_val, 1);
      chk("pos254_nonzero_vals", st_nz, 1);

      // Degree-2 locator with zero lambda1
`ifdef S3_CHS_FAIL_CHK_EN
      exp_fail_035 = 1;
`else
      exp_fail_035 = 0;
`endif
      run_cw(1, 0, 5, 'h33, 'h44);
      chk("l1zero_nonzero_vals", st_nz, 0);
      chk("l1zero_done", st_done, 1);
      chk("l1zero_fail", st_fail, exp_fail_035);

      // Second kes_done while scanning
      clr_stats();
      pulse(1, 1, 0, 'h5A, 0);
      repeat (9) @(posedge clk);
      pulse(1, 'h8E, 0, 1, 0);
      repeat (260) @(posedge clk);
      chk("overrun_pulses", st_ovr, 1);
      chk("overrun_done", st_done, 1);
      chk("overrun_eof_val", st_eof_val, 'h5A);
      chk("overrun_locs", st_loc, 1);

      // Reset in the middle of a scan
      clr_stats();
      pulse(1, 1, 0, 'h5A, 0);
      repeat (98) @(posedge clk);
      #1 rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("midreset_outputs", int'(act_vec[0]), 0);
      rstn = 1'b1;
      repeat (5) @(posedge clk);
      chk("midreset_no_done", st_done, 0);
      chk("midreset_no_eof", st_eof, 0);
      run_cw(1, 1, 0, 'h5A, 0);
      chk("after_reset_slots", st_slots, 255);
      chk("after_reset_done", st_done, 1);

      // Randomised codewords: genuine two-root locators, single roots and arbitrary coefficients
      for (int it = 0; it < 20; it++) begin
         mode = $urandom_range(0, 2);
         late = $urandom_range(0, 3);
         if (it % 2 == 1) begin
            p1 = $urandom_range(0, 4);
            p2 = (p1 + 1 + $urandom_range(0, 3)) % 5;
         end else begin
            p1 = $urandom_range(0, 254);
            p2 = (p1 + 1 + $urandom_range(0, 253)) % 255;
         end
         xa = alog[p1];
         xb = alog[p2];
         clr_stats();
         if (mode == 0)
            pulse(1, xa ^ xb, gmul(xa, xb), $urandom_range(0, 255), $urandom_range(0, 255));
         else if (mode == 1)
            pulse(1, xa, 0, $urandom_range(0, 255), $urandom_range(0, 255));
         else
            pulse($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(0, 255), $urandom_range(0, 255));
         repeat (255) @(posedge clk);
         if (late == 0) begin
            #1 kes_done = 1'b1;
            @(posedge clk);
            #1 kes_done = 1'b0;
         end
         repeat (5) @(posedge clk);
         if (mode == 0) chk("rand_two_roots", st_loc, 2);
         if (mode == 1) chk("rand_one_root", st_loc, 1);
         chk("rand_done", st_done, 1);
      end

      repeat (5) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
